// File: rtl/de1_soc_sysid_checker.sv
// de1_soc_sysid_checker
// Avalon-MM read master for the sysid slave. On start it reads word 0 (ID)
// and then word 1 (timestamp), captures both, and compares them with the
// build-time constants. The verdict is held until the next accepted start.
// Optional build macro: SYSID_CHK_TIMEOUT_EN. When defined, a read that
// stalls on waitrequest for TIMEOUT_CYCLES cycles is abandoned and flagged
// on the timeout output. Without it, the master waits indefinitely.
module de1_soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1455737899
`ifdef SYSID_CHK_TIMEOUT_EN
    ,
    parameter logic [7:0]  TIMEOUT_CYCLES     = 8'd255
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

    state_t state;
    logic   xfer_done;

    // A transfer completes in the cycle the slave stops stalling our request.
    assign xfer_done = avm_read & ~avm_waitrequest;

`ifdef SYSID_CHK_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       stall_expired;
    logic       timeout_q;

    // This stall cycle is the TIMEOUT_CYCLES-th one: the read gets abandoned at this edge.
    assign stall_expired = avm_read & avm_waitrequest &
                           (({1'b0, stall_cnt} + 9'd1) >= {1'b0, TIMEOUT_CYCLES});
    assign timeout = timeout_q;

    // Stall counter: restarts with every new read, counts waitrequest cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= 8'd0;
        end else if (avm_read && avm_waitrequest) begin
            stall_cnt <= stall_cnt + 8'd1;
        end else begin
            stall_cnt <= 8'd0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Sequencer: issues the two reads, captures the data and publishes the verdict.
    // NOTE: all state here is updated with <= so every branch sees the values from
    // before the edge (e.g. id_match compares the id_value captured last cycle).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
`ifdef SYSID_CHK_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a one-cycle pulse.
            done <= 1'b0;
`ifdef SYSID_CHK_TIMEOUT_EN
            if (stall_expired) begin
                // Abandon the stalled read; captured words are kept, matches forced low.
                avm_read  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                timeout_q <= 1'b1;
                id_match  <= 1'b0;
                ts_match  <= 1'b0;
                state     <= DONE;
            end else
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RD_ID;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b1;
                        id_value    <= 32'd0;
                        ts_value    <= 32'd0;
                        id_match    <= 1'b0;
                        ts_match    <= 1'b0;
`ifdef SYSID_CHK_TIMEOUT_EN
                        timeout_q   <= 1'b0;
`endif
                    end
                end
                RD_ID: begin
                    if (xfer_done) begin
                        // Back-to-back: keep read high and move straight to word 1.
                        id_value    <= avm_readdata;
                        avm_address <= 1'b1;
                        state       <= RD_TS;
                    end
                end
                RD_TS: begin
                    if (xfer_done) begin
                        ts_value <= avm_readdata;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        id_match <= (id_value == EXPECTED_ID);
                        ts_match <= (avm_readdata == EXPECTED_TIMESTAMP);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    avm_address <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_de1_soc_sysid_checker.sv
// tb_de1_soc_sysid_checker
// Directed and randomized checks of the sysid checker against a behavioural
// Avalon slave and a reference model derived from the read sequence timing.
// The timeout scenarios are compiled in only with SYSID_CHK_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_de1_soc_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1455737899;
    localparam int          TMO    = 4;
    localparam int          STUCK  = 1000000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        id_match;
    logic        ts_match;
    logic        timeout;

    always #5 clock = ~clock;

    de1_soc_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS)
`ifdef SYSID_CHK_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES     (8'(TMO))
`endif
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .id_match        (id_match),
        .ts_match        (ts_match),
        .timeout         (timeout)
    );

    // Slave contents and stall profile, written only by the stimulus.
    logic [31:0] mem [2];
    int          wait_cfg [2];

    // Monitor state, written only by the monitor processes.
    int   cyc = 0;
    int   served = 0;
    int   reads_q[$];
    int   done_cnt = 0;
    int   stab_err = 0;
    logic last_stall = 1'b0;
    logic last_addr = 1'b0;

    int errors = 0;
    int checks = 0;

    always @(posedge clock) cyc++;

    // Slave response, set up on the falling edge so it is stable at the rising edge.
    // While stalling, readdata carries junk that the master must ignore.
    always @(negedge clock) begin
        if (avm_read && served < wait_cfg[avm_address]) begin
            avm_waitrequest = 1'b1;
            avm_readdata    = $urandom;
        end else begin
            avm_waitrequest = 1'b0;
            avm_readdata    = avm_read ? mem[avm_address] : $urandom;
        end
    end

    // Bus monitor: logs completed transfers, counts done pulses and flags any
    // change of read/address during a stall other than a timeout abort.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            served     = 0;
            last_stall = 1'b0;
            reads_q.delete();
        end else begin
            if (last_stall && !timeout && (!avm_read || avm_address != last_addr))
                stab_err++;
            if (avm_read && avm_waitrequest) begin
                served++;
                last_stall = 1'b1;
                last_addr  = avm_address;
            end else begin
                if (avm_read) reads_q.push_back(int'(avm_address));
                served     = 0;
                last_stall = 1'b0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Pulse start for one cycle (cycle N, returned as t0), check the request
    // went out, then wait (bounded) for the done pulse.
    task automatic start_and_wait(input string tag, output int lat, output bit seen);
        int t0;
        @(negedge clock);
        start = 1'b1;
        t0    = cyc;
        @(negedge clock);
        start = 1'b0;
        check({tag, " busy"}, busy, 1'b1);
        check({tag, " read issued"}, avm_read, 1'b1);
        check({tag, " first address"}, avm_address, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clock);
        end
        lat = cyc - t0;
        check({tag, " done seen"}, seen, 1'b1);
    endtask

    // Full check: the model expects one issue cycle, (w+1) cycles per read,
    // and done in the cycle after the second completion.
    task automatic run_check(input string tag, input logic [31:0] m0, input logic [31:0] m1,
                             input int w0, input int w1);
        int lat;
        bit seen;
        int n0;
        int d0;
        mem[0]      = m0;
        mem[1]      = m1;
        wait_cfg[0] = w0;
        wait_cfg[1] = w1;
        n0 = reads_q.size();
        d0 = done_cnt;
        start_and_wait(tag, lat, seen);
        if (seen) begin
            check({tag, " latency"}, lat, 1 + (w0 + 1) + (w1 + 1));
            check({tag, " id_value"}, id_value, m0);
            check({tag, " ts_value"}, ts_value, m1);
            check({tag, " id_match"}, id_match, m0 == EXP_ID);
            check({tag, " ts_match"}, ts_match, m1 == EXP_TS);
            check({tag, " timeout"}, timeout, 1'b0);
            check({tag, " busy at done"}, busy, 1'b0);
            check({tag, " read off"}, avm_read, 1'b0);
            check({tag, " read count"}, reads_q.size() - n0, 2);
            if (reads_q.size() - n0 == 2) begin
                check({tag, " read 0 addr"}, reads_q[n0], 0);
                check({tag, " read 1 addr"}, reads_q[n0 + 1], 1);
            end
            @(negedge clock);
            check({tag, " done pulse"}, done_cnt - d0, 1);
            check({tag, " done low"}, done, 1'b0);
            check({tag, " id hold"}, id_value, m0);
            check({tag, " ts hold"}, ts_value, m1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int d0;
        int lat;
        bit seen;
        logic [31:0] r0;
        logic [31:0] r1;

        reset           = 1'b1;
        start           = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'd0;
        mem[0]          = EXP_ID;
        mem[1]          = EXP_TS;
        wait_cfg[0]     = 0;
        wait_cfg[1]     = 0;

        // Reset state, with start asserted to show it is ignored in reset.
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("reset read", avm_read, 1'b0);
        check("reset addr", avm_address, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset id", id_value, 32'd0);
        check("reset ts", ts_value, 32'd0);
        check("reset matches", {id_match, ts_match, timeout}, 3'b000);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Matching image, zero-wait slave.
        run_check("zero-wait", EXP_ID, EXP_TS, 0, 0);
        // Three stall cycles per read.
        run_check("wait3", EXP_ID, EXP_TS, 3, 3);
        // Wrong timestamp.
        run_check("bad ts", EXP_ID, 32'h1234_5678, 0, 0);
        // Wrong ID, correct timestamp, uneven stalls.
        run_check("bad id", 32'hDEAD_BEEF, EXP_TS, 2, 0);

        // Randomized slave contents and stall profiles.
        for (int i = 0; i < 8; i++) begin
            r0 = $urandom_range(0, 1) ? EXP_ID : $urandom;
            r1 = $urandom_range(0, 1) ? EXP_TS : $urandom;
            run_check($sformatf("rand%0d", i), r0, r1,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // start held high for 12 cycles: one check occupies 4 cycles
        // (issue, two reads, done), so exactly 3 checks and 6 reads happen.
        mem[0]      = EXP_ID;
        mem[1]      = EXP_TS;
        wait_cfg[0] = 0;
        wait_cfg[1] = 0;
        n0 = reads_q.size();
        d0 = done_cnt;
        @(negedge clock);
        start = 1'b1;
        repeat (12) @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        check("held reads", reads_q.size() - n0, (12 + 3) / 4 * 2);
        check("held dones", done_cnt - d0, (12 + 3) / 4);
        check("held idle busy", busy, 1'b0);

        // Reset while the timestamp read is pending.
        mem[0]      = 32'hA5A5_0001;
        mem[1]      = EXP_TS;
        wait_cfg[0] = 0;
        wait_cfg[1] = STUCK;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("mid ts read", avm_read, 1'b1);
        check("mid ts addr", avm_address, 1'b1);
        check("mid id captured", id_value, 32'hA5A5_0001);
        reset = 1'b1;
        #1;
        check("async rst read", avm_read, 1'b0);
        check("async rst busy", busy, 1'b0);
        check("async rst done", done, 1'b0);
        check("async rst id", id_value, 32'd0);
        check("async rst ts", ts_value, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        run_check("after reset", EXP_ID, EXP_TS, 1, 0);

`ifdef SYSID_CHK_TIMEOUT_EN
        // One stall short of the limit still completes normally.
        run_check("below limit", EXP_ID, EXP_TS, TMO - 1, TMO - 1);

        // ID read stuck: read drops after TMO stall cycles.
        mem[0]      = EXP_ID;
        mem[1]      = EXP_TS;
        wait_cfg[0] = STUCK;
        wait_cfg[1] = 0;
        n0 = reads_q.size();
        start_and_wait("tmo id", lat, seen);
        check("tmo id latency", lat, 1 + TMO);
        check("tmo id flag", timeout, 1'b1);
        check("tmo id read off", avm_read, 1'b0);
        check("tmo id matches", {id_match, ts_match}, 2'b00);
        check("tmo id values", id_value | ts_value, 32'd0);
        check("tmo id reads", reads_q.size() - n0, 0);
        @(negedge clock);
        check("tmo id done low", done, 1'b0);
        check("tmo id flag hold", timeout, 1'b1);

        // Timestamp read stuck: captured ID is kept, matches forced low.
        wait_cfg[0] = 2;
        wait_cfg[1] = STUCK;
        n0 = reads_q.size();
        start_and_wait("tmo ts", lat, seen);
        check("tmo ts latency", lat, 1 + (2 + 1) + TMO);
        check("tmo ts flag", timeout, 1'b1);
        check("tmo ts id kept", id_value, EXP_ID);
        check("tmo ts value", ts_value, 32'd0);
        check("tmo ts matches", {id_match, ts_match}, 2'b00);
        check("tmo ts reads", reads_q.size() - n0, 1);
        @(negedge clock);

        // A fresh check clears the timeout flag.
        run_check("after tmo", EXP_ID, EXP_TS, 0, 0);
`endif

        check("stall stability", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
